// File: rtl/lane_operand_buffer.sv
`default_nettype none
// ============================================================================
// Module   : lane_operand_buffer
// Brief    : Credit-controlled operand FIFO between VRF read crossbar and one FU.
// Revision : 1.0
// ============================================================================
module lane_operand_buffer #(
  parameter int DataWidth   = 64,
  parameter int BufferDepth = 4,
  parameter int CntWidth    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [CntWidth-1:0]  cmd_nwords_i,
  output logic                 credit_o,
  input  logic                 issue_i,
  input  logic [DataWidth-1:0] operand_i,
  input  logic                 operand_valid_i,
  output logic [DataWidth-1:0] operand_o,
  output logic                 operand_valid_o,
  input  logic                 operand_ready_i,
  output logic                 operand_last_o,
  output logic                 busy_o
);

  localparam int PTR_W = $clog2(BufferDepth);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(BufferDepth);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  issue_rem_q, issue_rem_d;
  logic [CntWidth-1:0]  out_rem_q, out_rem_d;
  logic [CNT_W-1:0]     fifo_count_q, fifo_count_d;
  logic [CNT_W-1:0]     inflight_q, inflight_d;
  logic [CNT_W-1:0]     discard_q, discard_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DataWidth-1:0] mem_q [BufferDepth];

  logic w_issue, w_ret, w_drop, w_push, w_pop;

  // Every output depends on registered state only.
  assign credit_o        = (state_q == ST_ACTIVE) && (issue_rem_q != '0) &&
                           ((fifo_count_q + inflight_q) < DEPTH);
  assign cmd_ready_o     = (state_q == ST_IDLE) && (discard_q == '0);
  assign operand_valid_o = (fifo_count_q != '0);
  assign operand_last_o  = operand_valid_o && (out_rem_q == CntWidth'(1));
  assign operand_o       = mem_q[rd_ptr_q];
  assign busy_o          = (state_q != ST_IDLE) || (inflight_q != '0);

  assign w_issue = issue_i && credit_o;
  assign w_ret   = operand_valid_i && (inflight_q != '0);
  assign w_drop  = w_ret && (discard_q != '0);
  assign w_push  = w_ret && !w_drop;
  assign w_pop   = operand_valid_o && operand_ready_i;

  always_comb begin
    state_d      = state_q;
    issue_rem_d  = issue_rem_q;
    out_rem_d    = out_rem_q;
    discard_d    = discard_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    inflight_d   = inflight_q + CNT_W'(w_issue) - CNT_W'(w_ret);
    fifo_count_d = fifo_count_q + CNT_W'(w_push) - CNT_W'(w_pop);

    if (w_issue) issue_rem_d = issue_rem_q - CntWidth'(1);
    if (w_drop)  discard_d   = discard_q - CNT_W'(1);
    if (w_push)  wr_ptr_d    = wr_ptr_q + PTR_W'(1);

    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (out_rem_q != '0) out_rem_d = out_rem_q - CntWidth'(1);
      if (operand_last_o)  state_d   = ST_IDLE;
    end

    if ((state_q == ST_IDLE) && cmd_valid_i && cmd_ready_o && (cmd_nwords_i != '0)) begin
      state_d     = ST_ACTIVE;
      issue_rem_d = cmd_nwords_i;
      out_rem_d   = cmd_nwords_i;
    end

    // Reads already granted still return; they are counted out via discard.
    if (flush_i) begin
      state_d      = ST_IDLE;
      issue_rem_d  = '0;
      out_rem_d    = '0;
      fifo_count_d = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      discard_d    = inflight_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      issue_rem_q  <= '0;
      out_rem_q    <= '0;
      fifo_count_q <= '0;
      inflight_q   <= '0;
      discard_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      issue_rem_q  <= issue_rem_d;
      out_rem_q    <= out_rem_d;
      fifo_count_q <= fifo_count_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BufferDepth; i++) mem_q[i] <= '0;
    end else if (w_push) begin
      mem_q[wr_ptr_q] <= operand_i;
    end
  end

  a_issue_without_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(issue_i && !credit_o));
  a_return_without_read: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(operand_valid_i && (inflight_q == '0)));
  a_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_push && !w_pop && (fifo_count_q == DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_lane_operand_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lane_operand_buffer
// Brief    : Randomized self-checking bench with a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_lane_operand_buffer;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [CW-1:0] cmd_nwords_i;
  logic          credit_o;
  logic          issue_i;
  logic [DW-1:0] operand_i;
  logic          operand_valid_i;
  logic [DW-1:0] operand_o;
  logic          operand_valid_o;
  logic          operand_ready_i;
  logic          operand_last_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  lane_operand_buffer #(
    .DataWidth  (DW),
    .BufferDepth(DEPTH),
    .CntWidth   (CW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_nwords_i   (cmd_nwords_i),
    .credit_o       (credit_o),
    .issue_i        (issue_i),
    .operand_i      (operand_i),
    .operand_valid_i(operand_valid_i),
    .operand_o      (operand_o),
    .operand_valid_o(operand_valid_o),
    .operand_ready_i(operand_ready_i),
    .operand_last_o (operand_last_o),
    .busy_o         (busy_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: words waiting for the FU, plus instruction bookkeeping.
  logic [DW-1:0] m_q[$];
  bit            m_active;
  int            m_issue_rem, m_out_rem, m_inflight, m_discard;
  bit            ret_pend;
  logic [DW-1:0] ret_word;
  int            n_delivered, n_last;

  task automatic reset_model();
    m_q.delete();
    m_active    = 0;
    m_issue_rem = 0;
    m_out_rem   = 0;
    m_inflight  = 0;
    m_discard   = 0;
    ret_pend    = 0;
    ret_word    = '0;
  endtask

  // One clock cycle: compare outputs with the model, drive inputs, advance both.
  task automatic step(input bit want_issue, input bit rdy, input bit flush,
                      input bit cv, input int nw);
    bit e_credit, e_valid, e_last, e_ready, e_busy, iss, pop;
    e_credit = m_active && (m_issue_rem != 0) && ((m_q.size() + m_inflight) < DEPTH);
    e_valid  = (m_q.size() != 0);
    e_last   = e_valid && (m_out_rem == 1);
    e_ready  = !m_active && (m_discard == 0);
    e_busy   = m_active || (m_inflight != 0);

    n_vec++;
    if (credit_o !== e_credit) begin
      n_err++; $display("FAIL credit @%0t: got %b expected %b", $time, credit_o, e_credit);
    end
    n_vec++;
    if (operand_valid_o !== e_valid) begin
      n_err++; $display("FAIL valid @%0t: got %b expected %b", $time, operand_valid_o, e_valid);
    end
    n_vec++;
    if (operand_last_o !== e_last) begin
      n_err++; $display("FAIL last @%0t: got %b expected %b", $time, operand_last_o, e_last);
    end
    n_vec++;
    if (cmd_ready_o !== e_ready) begin
      n_err++; $display("FAIL cmd_ready @%0t: got %b expected %b", $time, cmd_ready_o, e_ready);
    end
    n_vec++;
    if (busy_o !== e_busy) begin
      n_err++; $display("FAIL busy @%0t: got %b expected %b", $time, busy_o, e_busy);
    end
    if (e_valid) begin
      n_vec++;
      if (operand_o !== m_q[0]) begin
        n_err++; $display("FAIL data @%0t: got %h expected %h", $time, operand_o, m_q[0]);
      end
    end

    iss = want_issue && e_credit;
    pop = e_valid && rdy;
    issue_i         = iss;
    operand_ready_i = rdy;
    flush_i         = flush;
    cmd_valid_i     = cv;
    cmd_nwords_i    = CW'(nw);
    operand_valid_i = ret_pend;
    operand_i       = ret_word;

    if (pop) begin
      n_delivered++;
      if (m_out_rem == 1) n_last++;
      void'(m_q.pop_front());
      m_out_rem--;
      if (m_out_rem == 0) m_active = 0;
    end
    if (ret_pend) begin
      m_inflight--;
      if (m_discard > 0) m_discard--;
      else m_q.push_back(ret_word);
    end
    if (iss) begin
      m_inflight++;
      m_issue_rem--;
    end
    if (cv && e_ready && nw != 0) begin
      m_active    = 1;
      m_issue_rem = nw;
      m_out_rem   = nw;
    end
    if (flush) begin
      m_q.delete();
      m_active    = 0;
      m_issue_rem = 0;
      m_out_rem   = 0;
      m_discard   = m_inflight;
    end

    @(posedge clk_i); #1;
    ret_pend    = iss;
    ret_word    = {$urandom, $urandom};
    issue_i     = 1'b0;
    flush_i     = 1'b0;
    cmd_valid_i = 1'b0;
  endtask

  task automatic run_to_idle(input bit rand_iss, input bit rand_rdy, input int max_cyc);
    int i = 0;
    while ((m_active || m_inflight != 0) && i < max_cyc) begin
      step(rand_iss ? ($urandom_range(0, 3) != 0) : 1'b1,
           rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0, 0);
      i++;
    end
    n_vec++;
    if (m_active || m_inflight != 0) begin
      n_err++; $display("FAIL timeout: instruction still open after %0d cycles (required idle)", max_cyc);
    end
  endtask

  task automatic test_reset();
    int first_v, last_v;
    rst_ni = 1'b0; flush_i = 0; cmd_valid_i = 0; cmd_nwords_i = '0; issue_i = 0;
    operand_i = '0; operand_valid_i = 0; operand_ready_i = 0;
    reset_model();
    repeat (2) @(posedge clk_i);
    #1;
    n_vec++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready_o); end
    n_vec++; if (credit_o !== 1'b0) begin n_err++; $display("FAIL rst_credit: got %b expected 0", credit_o); end
    n_vec++; if (operand_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", operand_valid_o); end
    n_vec++; if (operand_last_o !== 1'b0) begin n_err++; $display("FAIL rst_last: got %b expected 0", operand_last_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
    n_vec++; if (operand_o !== '0) begin n_err++; $display("FAIL rst_data: got %h expected 0", operand_o); end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    n_delivered = 0; n_last = 0; first_v = -1; last_v = -1;
    step(1'b0, 1'b1, 1'b0, 1'b1, 5);
    for (int i = 1; i < 40 && (m_active || m_inflight != 0); i++) begin
      if (operand_valid_o === 1'b1) begin
        if (first_v < 0) first_v = i;
        last_v = i;
      end
      step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    end
    n_vec++; if (first_v !== 3) begin n_err++; $display("FAIL first_word_cycle: got %0d expected 3", first_v); end
    n_vec++; if (last_v - first_v !== 4) begin n_err++; $display("FAIL burst_span: got %0d expected 4", last_v - first_v); end
    n_vec++; if (n_delivered !== 5) begin n_err++; $display("FAIL words_5: got %0d expected 5", n_delivered); end
    n_vec++; if (n_last !== 1) begin n_err++; $display("FAIL last_count: got %0d expected 1", n_last); end
    n_vec++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL ready_after_last: got %b expected 1", cmd_ready_o); end
  endtask

  task automatic test_back_pressure();
    int credits = 0;
    n_delivered = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 8);
    for (int i = 0; i < 10; i++) begin
      if (credit_o === 1'b1) credits++;
      step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    end
    n_vec++; if (credits !== DEPTH) begin n_err++; $display("FAIL bp_credits: got %0d expected %0d", credits, DEPTH); end
    run_to_idle(1'b0, 1'b0, 60);
    n_vec++; if (n_delivered !== 8) begin n_err++; $display("FAIL bp_words: got %0d expected 8", n_delivered); end
  endtask

  task automatic test_zero_length();
    step(1'b1, 1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (cmd_ready_o !== 1'b1 || credit_o !== 1'b0 || operand_valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL zero_len: ready/credit/valid got %b%b%b expected 100",
                 cmd_ready_o, credit_o, operand_valid_o);
      end
      step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    end
  endtask

  task automatic test_flush(input bit same_cycle);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    if (same_cycle) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 0);
    end else begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    end
    n_vec++; if (operand_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %b expected 0", operand_valid_o); end
    n_vec++; if (busy_o !== same_cycle) begin n_err++; $display("FAIL flush_busy: got %b expected %b", busy_o, same_cycle); end
    n_vec++; if (cmd_ready_o !== !same_cycle) begin n_err++; $display("FAIL flush_ready: got %b expected %b", cmd_ready_o, !same_cycle); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_busy_fall: got %b expected 0", busy_o); end
    n_delivered = 0;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1);
    run_to_idle(1'b0, 1'b0, 20);
    n_vec++; if (n_delivered !== 1) begin n_err++; $display("FAIL flush_next_words: got %0d expected 1", n_delivered); end
  endtask

  task automatic test_full_push_pop();
    step(1'b0, 1'b0, 1'b0, 1'b1, 8);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (dut.fifo_count_q !== 3'd3) begin n_err++; $display("FAIL pre_count: got %0d expected 3", dut.fifo_count_q); end
    n_vec++; if (credit_o !== 1'b0) begin n_err++; $display("FAIL full_credit: got %b expected 0", credit_o); end
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    n_vec++; if (dut.fifo_count_q !== 3'd3) begin n_err++; $display("FAIL pushpop_count: got %0d expected 3", dut.fifo_count_q); end
    n_vec++; if (credit_o !== 1'b1) begin n_err++; $display("FAIL credit_reassert: got %b expected 1", credit_o); end
    run_to_idle(1'b0, 1'b0, 40);
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1, 1'b0, 1'b1, 6);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    operand_valid_i = 1'b1;
    operand_i       = ret_word;
    rst_ni          = 1'b0;
    #1;
    n_vec++;
    if (cmd_ready_o !== 1'b1 || credit_o !== 1'b0 || operand_valid_o !== 1'b0 ||
        operand_last_o !== 1'b0 || busy_o !== 1'b0 || operand_o !== '0) begin
      n_err++;
      $display("FAIL async_rst: ready/credit/valid/last/busy got %b%b%b%b%b data %h expected 10000 data 0",
               cmd_ready_o, credit_o, operand_valid_o, operand_last_o, busy_o, operand_o);
    end
    @(posedge clk_i); #1;
    n_vec++;
    if (operand_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL rst_data_ignored: valid/busy got %b%b expected 00", operand_valid_o, busy_o);
    end
    operand_valid_i = 1'b0;
    #1;
    rst_ni = 1'b1;
    reset_model();
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 3);
    run_to_idle(1'b0, 1'b0, 20);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int i = 0;
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, $urandom_range(1, 12));
      while ((m_active || m_inflight != 0) && i < 200) begin
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             (k >= 4) && ($urandom_range(0, 29) == 0), 1'b0, 0);
        i++;
      end
      n_vec++;
      if (m_active || m_inflight != 0) begin
        n_err++; $display("FAIL random_timeout: iteration %0d still open (required idle)", k);
      end
      while (m_discard != 0 && i < 220) begin
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        i++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_pressure();
    test_zero_length();
    test_flush(1'b0);
    test_flush(1'b1);
    test_full_push_pop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/lane_operand_buffer.md
# lane_operand_buffer

Per-lane operand buffer between the lane's vector register file read crossbar and one functional-unit input. It accepts one instruction command at a time, grants read credits to the operand requester so that in-flight VRF reads never overflow the buffer, stores the words returned one cycle after each read, and presents them to the functional unit over a valid/ready handshake with an end-of-instruction marker. One instance exists per operand queue, i.e. `NrOperandQueues` instances per lane.

## Interface

**Parameters**

- `DataWidth`, default 64: operand word width. Equals `$bits(elen_t)`.
- `BufferDepth`, default 4: number of FIFO entries. Must be a power of two and at least 2.
- `CntWidth`, default 16: width of the instruction word counters.

**Ports**

- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. **Asynchronous, active-low.**
- `flush_i` in 1: synchronous abort of the current instruction.
- `cmd_valid_i` in 1: new instruction command valid.
- `cmd_ready_o` out 1: command accepted; high only in IDLE.
- `cmd_nwords_i` in CntWidth: number of operand words the instruction needs.
- `credit_o` out 1: requester may issue one VRF read for this queue this cycle.
- `issue_i` in 1: requester's read for this queue was granted this cycle.
- `operand_i` in DataWidth: word from the VRF crossbar.
- `operand_valid_i` in 1: `operand_i` valid.
- `operand_o` out DataWidth: word to the functional unit.
- `operand_valid_o` out 1: `operand_o` valid.
- `operand_ready_i` in 1: functional unit consumes the word.
- `operand_last_o` out 1: `operand_o` is the final word of the instruction.
- `busy_o` out 1: state is not IDLE, or in-flight reads are outstanding.

## Operation

**State machine.** States are IDLE and ACTIVE.

- IDLE → ACTIVE on `cmd_valid_i && cmd_ready_o` with `cmd_nwords_i != 0`. At that point load `issue_rem = out_rem = cmd_nwords_i`.
- A command with `cmd_nwords_i == 0` is accepted and the state stays IDLE. No output and no credit result.
- ACTIVE → IDLE on an output handshake while `operand_last_o` is high.
- `flush_i` in any state forces IDLE, empties the FIFO, and zeroes `issue_rem` and `out_rem`.
- `flush_i` has priority over a command or output handshake in the same cycle.

**Credits.**

- `credit_o = ACTIVE && issue_rem != 0 && (fifo_count + inflight) < BufferDepth`.
- `issue_i` decrements `issue_rem` and increments `inflight`.
- `issue_i` while `credit_o` is low is illegal. Flag it with an assertion; the counters ignore it.

**Data return.**

- `operand_valid_i` decrements `inflight`.
- If `discard` is non-zero, decrement `discard` and drop the word.
- Otherwise push `operand_i` into the FIFO.
- `operand_valid_i` with `inflight == 0` is illegal: assert, and drop the word.

**Flush with reads in flight.**

- On flush, load `discard = inflight` (after this cycle's issue/return updates). `inflight` itself is not cleared.
- Words returning after the flush are dropped. `busy_o` stays high until `inflight == 0`.
- `cmd_ready_o` is held low while `discard != 0`, so a new instruction never receives stale data.

**Output.**

- `operand_valid_o = fifo_count != 0`. `operand_o` is the FIFO head.
- `operand_last_o = operand_valid_o && out_rem == 1`.
- A handshake pops the head and decrements `out_rem`.

**Simultaneous events.**

- Push and pop in the same cycle leave `fifo_count` unchanged.
- A push when full cannot occur given the credit rule; assert on it.
- Issue and return in the same cycle leave `inflight` unchanged.

**Widths.**

- `fifo_count` and `inflight` are `$clog2(BufferDepth)+1` bits wide.
- Pointers wrap modulo BufferDepth.
- Counters never underflow; the decrement is guarded by the non-zero check.

## Timing

- Reset values: state IDLE, all counters 0, FIFO empty.
  - `cmd_ready_o = 1`.
  - `credit_o`, `operand_valid_o`, `operand_last_o`, `busy_o` = 0.
  - `operand_o = '0`.
- Command accepted in cycle t → `credit_o` can first be high in t+1.
- `issue_i` in t → VRF data arrives in t+1 → `operand_valid_o` in t+2. There is no fall-through path.
- All outputs are driven from registers only. There is no combinational path from `operand_ready_i` or `issue_i` to `credit_o`.
  - `credit_o` in cycle t+1 reflects the pop/issue of cycle t.
  - Consequence: throughput is one word per cycle only if `BufferDepth >= 3`. The default of 4 sustains it.
- Final output handshake in cycle t → `cmd_ready_o` is high in t+1.

## Test plan

- **Reset.** Reset, then command nwords=5 with ready held high and `issue_i = credit_o`.
  - Expect 5 words in order on consecutive cycles after a 2-cycle fill latency.
  - `operand_last_o` is high only on word 5.
  - `cmd_ready_o` returns 1 the cycle after word 5.
- **Back-pressure.** nwords=8, `operand_ready_i = 0`.
  - `credit_o` drops after exactly 4 issues.
  - Release ready: all 8 words delivered, none lost or duplicated.
- **Zero-length command.** nwords=0 → `cmd_ready_o` stays 1, and `credit_o` and `operand_valid_o` never assert.
- **Flush with reads in flight.** Flush in the cycle after 2 issues.
  - The FIFO empties and both returning words are dropped.
  - `busy_o` falls once `inflight` reaches 0.
  - A next command of nwords=1 delivers only its own word.
- **Simultaneous push/pop at full.** BufferDepth=4, FIFO at 3 entries plus 1 in flight, with a pop and a return in the same cycle.
  - `fifo_count` stays 3.
  - `credit_o` is reasserted in the next cycle.
- **Asynchronous reset mid-instruction.** Assert `rst_ni` low mid-instruction.
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - Returning VRF data after reset is ignored.
